// File: rtl/rv32e_alu_pkg.sv
// Shared definitions for the rv32e ALU and its requester arbiter.
// Op codes, FSM state type and the round-robin index helper live here.
package rv32e_alu_pkg;

    localparam int unsigned N_REQ_MAX = 4;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SLL  = 4'b0101;
    localparam logic [3:0] ALU_SRL  = 4'b0110;
    localparam logic [3:0] ALU_SRA  = 4'b0111;
    localparam logic [3:0] ALU_SLT  = 4'b1000;
    localparam logic [3:0] ALU_SLTU = 4'b1001;
    localparam logic [3:0] ALU_SEQ  = 4'b1010;
    localparam logic [3:0] ALU_SNE  = 4'b1011;
    localparam logic [3:0] ALU_SGE  = 4'b1100;
    localparam logic [3:0] ALU_SGEU = 4'b1101;
    localparam logic [3:0] ALU_SGT  = 4'b1110;
    localparam logic [3:0] ALU_SGTU = 4'b1111;

    typedef enum logic [1:0] {
        StIdle,
        StExec,
        StResp
    } alu_arb_state_e;

    // Requester visited k steps after base, wrapping at n.
    function automatic int unsigned rr_index(int unsigned base, int unsigned k, int unsigned n);
        return (base + k) % n;
    endfunction

endpackage

// File: rtl/rv32e_alu.sv
// Combinational rv32e ALU: 16 ops, zero/neg flags on the result,
// overflow reported for ADD/SUB only.
module rv32e_alu
    import rv32e_alu_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] result,
    output logic        zero,
    output logic        neg,
    output logic        ovf
);

    logic [31:0] sum;
    logic [31:0] diff;

    assign sum  = a + b;
    assign diff = a - b;

    always_comb begin
        result = '0;
        ovf    = 1'b0;
        unique case (op)
            ALU_ADD: begin
                result = sum;
                ovf    = (a[31] == b[31]) && (sum[31] != a[31]);
            end
            ALU_SUB: begin
                result = diff;
                ovf    = (a[31] != b[31]) && (diff[31] != a[31]);
            end
            ALU_AND:  result = a & b;
            ALU_OR:   result = a | b;
            ALU_XOR:  result = a ^ b;
            ALU_SLL:  result = a << b[4:0];
            ALU_SRL:  result = a >> b[4:0];
            ALU_SRA:  result = $unsigned($signed(a) >>> b[4:0]);
            ALU_SLT:  result = {31'b0, $signed(a) < $signed(b)};
            ALU_SLTU: result = {31'b0, a < b};
            ALU_SEQ:  result = {31'b0, a == b};
            ALU_SNE:  result = {31'b0, a != b};
            ALU_SGE:  result = {31'b0, $signed(a) >= $signed(b)};
            ALU_SGEU: result = {31'b0, a >= b};
            ALU_SGT:  result = {31'b0, $signed(a) > $signed(b)};
            ALU_SGTU: result = {31'b0, a > b};
        endcase
    end

    assign zero = (result == '0);
    assign neg  = result[31];

endmodule

// File: rtl/rv32e_alu_arbiter.sv
// Shares one rv32e_alu between N_REQ requesters with registered responses.
// Define ALU_ARB_ROUND_ROBIN_EN for round-robin; otherwise lowest index wins.
module rv32e_alu_arbiter
    import rv32e_alu_pkg::*;
#(
    parameter int unsigned N_REQ = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_REQ-1:0]     req_valid,
    output logic [N_REQ-1:0]     req_ready,
    input  logic [4*N_REQ-1:0]   req_op,
    input  logic [32*N_REQ-1:0]  req_a,
    input  logic [32*N_REQ-1:0]  req_b,
    output logic [N_REQ-1:0]     rsp_valid,
    input  logic [N_REQ-1:0]     rsp_ready,
    output logic [31:0]          rsp_result,
    output logic                 rsp_zero,
    output logic                 rsp_neg,
    output logic                 rsp_ovf
);

    localparam int unsigned IDX_W = $clog2(N_REQ);

    alu_arb_state_e   state_q;
    logic [3:0]       op_q;
    logic [31:0]      a_q;
    logic [31:0]      b_q;
    logic [IDX_W-1:0] owner_q;

    logic [N_REQ-1:0] grant;
    logic [IDX_W-1:0] grant_idx;
    logic             grant_found;
    logic [3:0]       sel_op;
    logic [31:0]      sel_a;
    logic [31:0]      sel_b;
    logic             owner_ready;
    logic             can_accept;
    logic             accept;

    logic [31:0]      alu_result;
    logic             alu_zero;
    logic             alu_neg;
    logic             alu_ovf;

`ifdef ALU_ARB_ROUND_ROBIN_EN
    logic [IDX_W-1:0] last_grant_q;

    always_comb begin
        grant       = '0;
        grant_idx   = '0;
        grant_found = 1'b0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            if (!grant_found &&
                req_valid[rr_index(int'(last_grant_q) + 1, k, N_REQ)]) begin
                grant[rr_index(int'(last_grant_q) + 1, k, N_REQ)] = 1'b1;
                grant_idx   = IDX_W'(rr_index(int'(last_grant_q) + 1, k, N_REQ));
                grant_found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= IDX_W'(N_REQ - 1);
        end else if (accept) begin
            last_grant_q <= grant_idx;
        end
    end
`else
    always_comb begin
        grant       = '0;
        grant_idx   = '0;
        grant_found = 1'b0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            if (!grant_found && req_valid[k]) begin
                grant[k]    = 1'b1;
                grant_idx   = IDX_W'(k);
                grant_found = 1'b1;
            end
        end
    end
`endif

    always_comb begin
        sel_op = '0;
        sel_a  = '0;
        sel_b  = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (grant[i]) begin
                sel_op = req_op[i*4 +: 4];
                sel_a  = req_a[i*32 +: 32];
                sel_b  = req_b[i*32 +: 32];
            end
        end
    end

    // rsp_valid is one-hot on the owner while in RESP, so this picks rsp_ready[owner_q].
    assign owner_ready = |(rsp_valid & rsp_ready);
    assign can_accept  = rst_n &&
                         ((state_q == StIdle) || ((state_q == StResp) && owner_ready));
    assign req_ready   = can_accept ? grant : '0;
    assign accept      = |req_ready;

    rv32e_alu u_alu (
        .op     (op_q),
        .a      (a_q),
        .b      (b_q),
        .result (alu_result),
        .zero   (alu_zero),
        .neg    (alu_neg),
        .ovf    (alu_ovf)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            op_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            owner_q    <= '0;
            rsp_valid  <= '0;
            rsp_result <= '0;
            rsp_zero   <= 1'b0;
            rsp_neg    <= 1'b0;
            rsp_ovf    <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        op_q    <= sel_op;
                        a_q     <= sel_a;
                        b_q     <= sel_b;
                        owner_q <= grant_idx;
                        state_q <= StExec;
                    end
                end
                StExec: begin
                    rsp_result <= alu_result;
                    rsp_zero   <= alu_zero;
                    rsp_neg    <= alu_neg;
                    rsp_ovf    <= alu_ovf;
                    rsp_valid  <= {{(N_REQ-1){1'b0}}, 1'b1} << owner_q;
                    state_q    <= StResp;
                end
                StResp: begin
                    if (owner_ready) begin
                        rsp_valid <= '0;
                        if (accept) begin
                            op_q    <= sel_op;
                            a_q     <= sel_a;
                            b_q     <= sel_b;
                            owner_q <= grant_idx;
                            state_q <= StExec;
                        end else begin
                            state_q <= StIdle;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
